// File: rtl/main_mem_line_master.sv
// Line-to-byte initiator for the byte-wide main memory bus.
// Ports: clk/reset, req_* line request, resp_* completion, mem_* memory bus.
// Optional readback check: define MAIN_MEM_LINE_RDBK_CHECK_EN.
module main_mem_line_master #(
  parameter int LINE_BYTES = 16,
  parameter int READ_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [LINE_BYTES*8-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    mem_cs,
  output logic                    mem_oe,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  inout  wire  [7:0]              mem_data
);

  localparam int AW = $clog2(LINE_BYTES);
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int LW = LINE_BYTES * 8;
  localparam logic [AW-1:0] LAST = AW'(LINE_BYTES - 1);
  localparam logic [WW-1:0] WLAST = WW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
    CHK,
`endif
    RESP
  } state_t;

  state_t        state;
  logic [31:0]   base;
  logic [LW-1:0] wline;
  logic [LW-1:0] rbuf;
  logic [LW-1:0] rd_line;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [WW-1:0] wt;
  logic [31:0]   addr_nxt;
  logic [31:0]   req_base;
  logic          drv;
  logic [7:0]    dout;
  logic          last_wait;
  logic          last_byte;
  logic          addr_lsb_unused;

  // Only WR enables the driver, so it never shares a cycle with OE.
  assign mem_data = drv ? dout : 8'hzz;

  assign addr_lsb_unused = ^req_addr[AW-1:0];
  assign req_base  = {req_addr[31:AW], {AW{1'b0}}};
  assign cnt_nxt   = cnt + AW'(1);
  assign addr_nxt  = base + 32'(cnt_nxt);
  assign last_wait = (wt == WLAST);
  assign last_byte = (cnt == LAST);

  // Read buffer with the byte arriving this cycle merged in, so the
  // final byte can land in resp_rdata on the same edge.
  always_comb begin
    rd_line = rbuf;
    rd_line[{cnt, 3'b000} +: 8] = mem_data;
  end

`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
  logic err_acc;
  logic mismatch;
  assign mismatch = (mem_data != wline[{cnt, 3'b000} +: 8]);
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_cs     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      drv        <= 1'b0;
      dout       <= '0;
      cnt        <= '0;
      wt         <= '0;
      base       <= '0;
      wline      <= '0;
      rbuf       <= '0;
`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
      resp_err   <= 1'b0;
      err_acc    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            base      <= req_base;
            wline     <= req_wdata;
            cnt       <= '0;
            wt        <= '0;
            mem_cs    <= 1'b1;
            mem_addr  <= req_base;
            if (req_write) begin
              state  <= WR;
              mem_we <= 1'b1;
              drv    <= 1'b1;
              dout   <= req_wdata[7:0];
            end else begin
              state  <= RD;
              mem_oe <= 1'b1;
            end
          end
        end

        WR: begin
          if (last_byte) begin
            mem_we <= 1'b0;
            drv    <= 1'b0;
`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
            state    <= CHK;
            cnt      <= '0;
            wt       <= '0;
            mem_oe   <= 1'b1;
            mem_addr <= base;
            err_acc  <= 1'b0;
`else
            state      <= RESP;
            mem_cs     <= 1'b0;
            resp_valid <= 1'b1;
`endif
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= addr_nxt;
            dout     <= wline[{cnt_nxt, 3'b000} +: 8];
          end
        end

        RD: begin
          if (last_wait) begin
            wt   <= '0;
            rbuf <= rd_line;
            if (last_byte) begin
              state      <= RESP;
              mem_cs     <= 1'b0;
              mem_oe     <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= rd_line;
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= addr_nxt;
            end
          end else begin
            wt <= wt + WW'(1);
          end
        end

`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
        CHK: begin
          if (last_wait) begin
            wt      <= '0;
            err_acc <= err_acc | mismatch;
            if (last_byte) begin
              state      <= RESP;
              mem_cs     <= 1'b0;
              mem_oe     <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= err_acc | mismatch;
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= addr_nxt;
            end
          end else begin
            wt <= wt + WW'(1);
          end
        end
`endif

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
`ifdef MAIN_MEM_LINE_RDBK_CHECK_EN
          resp_err   <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_cs    <= 1'b0;
          mem_oe    <= 1'b0;
          mem_we    <= 1'b0;
          drv       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/main_mem_line_master.md
Name: main_mem_line_master

Overview:
- Initiator for the main memory's byte-wide bus: CS, OE, WE, a 32-bit Addr and a bidirectional 8-bit Data.
- Takes whole-line read/write requests from the cache side and turns each into a sequence of single-byte memory accesses.
- Assembles read bytes into a line and signals completion with a one-cycle response pulse.
- Sits between the cache controller and the main memory; it is the only driver of the memory's control, address and write-data lines.

Parameters:
- LINE_BYTES, 16, bytes per line; power of two, 2..64.
- READ_LAT, 2, cycles each read address/OE is held; Data is sampled at the rising edge that ends the last held cycle; range 1..4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle; request accepted on an edge where req_valid and req_ready are both 1.
- req_write  input  1  1 = write line, 0 = read line.
- req_addr  input  32  line address; low log2(LINE_BYTES) bits are ignored and treated as 0.
- req_wdata  input  LINE_BYTES*8  write line; byte i is bits [8i+7:8i] and goes to base+i.
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_rdata  output  LINE_BYTES*8  read line, same byte order; held until the next read completes.
- resp_err  output  1  readback mismatch; valid with resp_valid; tied 0 without the optional feature.
- mem_cs  output  1  chip select to memory.
- mem_oe  output  1  output enable to memory.
- mem_we  output  1  write enable to memory.
- mem_addr  output  32  byte address to memory.
- mem_data  inout  8  driven only while writing; high-Z otherwise.

Behaviour:
- Reset values: req_ready=1 after the reset edge; resp_valid, resp_err, mem_cs, mem_oe, mem_we = 0; mem_addr=0; resp_rdata=0; mem_data driver released (high-Z).
- Reset in the middle of a transfer aborts it immediately. No response is issued and no further memory cycles occur.
- Request capture on accept: line base address, write line data, transfer type. The byte counter is cleared.
- FSM states: IDLE, WR, RD, RESP (plus CHK with the optional feature).
- IDLE:
  - req_ready=1, mem_cs=0, driver off.
  - On accept, go to WR or RD; the first memory cycle appears on the next cycle.
- WR, one cycle per byte:
  - mem_cs=1, mem_we=1, mem_oe=0, mem_addr=base+cnt, mem_data=byte[cnt].
  - After byte LINE_BYTES-1, go to RESP.
  - A write line takes LINE_BYTES cycles; WE stays high for consecutive bytes.
- RD, READ_LAT cycles per byte:
  - mem_cs=1, mem_oe=1, mem_we=0, mem_addr=base+cnt, driver off.
  - A wait counter runs 0..READ_LAT-1. On its final edge, mem_data is stored into byte[cnt] of the read buffer, then cnt increments.
  - After the last byte, go to RESP.
  - A read line takes LINE_BYTES*READ_LAT cycles.
- RESP:
  - mem_cs=mem_oe=mem_we=0; resp_valid=1 for exactly one cycle.
  - On reads, resp_rdata updates on the same edge resp_valid rises.
  - Next cycle returns to IDLE, so at least one idle bus cycle separates transactions.
- Bus turnaround:
  - The driver is enabled only in WR and only in the same cycle as mem_we=1. It never overlaps a cycle with mem_oe=1.
  - No write follows a read without at least one CS=0 cycle in between (RESP plus IDLE).
- Address arithmetic:
  - base + cnt is 32-bit modulo.
  - A line at 32'hFFFFFFF0 with LINE_BYTES=16 ends at 32'hFFFFFFFF with no carry out; wrap-around is legal.
- req_valid while busy is ignored (req_ready=0); the requester holds it.
- Request fields are sampled only at accept; later changes to them have no effect.

Optional Feature:
- Macro: MAIN_MEM_LINE_RDBK_CHECK_EN.
- Defined:
  - After WR completes, the block enters CHK instead of RESP.
  - CHK re-reads the full line using RD timing and compares each byte against the captured write data.
  - RESP then asserts resp_valid, with resp_err=1 if any byte differed.
  - Write latency becomes LINE_BYTES*(1+READ_LAT) cycles before RESP.
  - resp_rdata is not updated by the readback.
- Undefined: no CHK state; resp_err is constant 0.

Test Plan:
- Reset, then a write of line 0x00000100 with bytes 0x00..0x0F -> 16 consecutive cycles of CS=WE=1 with Addr 0x100..0x10F and Data 0x00..0x0F. resp_valid pulses on cycle 17 after accept.
- Read of 0x00000100 from a memory model preloaded with 0xA0..0xAF, READ_LAT=2 -> each Addr held 2 cycles with OE=1 and Data high-Z from the master. resp_valid arrives 33 cycles after accept with resp_rdata byte0=0xA0 ... byte15=0xAF.
- req_addr=0x00000107 -> accesses start at 0x100. Also: line at 0xFFFFFFF0 -> last Addr is 0xFFFFFFFF, and the block returns to IDLE cleanly.
- Assert reset after 5 bytes of a write -> next cycle CS=WE=0 and Data high-Z; no resp_valid ever appears; req_ready=1 afterwards; a new read then completes normally.
- Back-to-back requests:
  - Write followed by read with req_valid held -> the second request is accepted only after RESP; at least one CS=0 cycle separates them.
  - Across the whole run, the master never drives Data in a cycle with OE=1.
- With MAIN_MEM_LINE_RDBK_CHECK_EN, the memory model corrupts byte 3 on write -> resp_err=1 with resp_valid after the readback. Without corruption, resp_err=0.
